// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared state type and constants for the FIR stream sequencer
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } fir_ctrl_state_t;

  localparam int FIR_DIN_W = 16;
  localparam int FIR_ACC_W = 64;
  // Coefficients are Q31, so the accumulator carries 31 fractional bits
  localparam int COEF_FRAC = 31;

endpackage

// File: rtl/fir_ctrl_fifo.sv
// rtl/fir_ctrl_fifo.sv - synchronous skid FIFO, DEPTH x W, with occupancy level
module fir_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - stream sequencer feeding a free-running pipelined FIR
// Optional FIR_OUT_SAT_EN: saturate the scaled output instead of wrapping it.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DIN_W     = FIR_DIN_W,
  parameter int ACC_W     = FIR_ACC_W,
  parameter int OUT_W     = 16,
  parameter int LATENCY   = 102,
  parameter int FLUSH_LEN = 202,
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             s_valid,
  input  logic [DIN_W-1:0] s_data,
  output logic             s_ready,
  output logic             fir_rst,
  output logic [DIN_W-1:0] fir_din,
  input  logic [ACC_W-1:0] fir_dout,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             busy,
  output logic             underrun,
  output logic [31:0]      sample_cnt
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(FLUSH_LEN + 1);

  fir_ctrl_state_t state_q, state_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DIN_W-1:0] fifo_head;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             flush_zero;
  logic [DIN_W-1:0] feed_data;
  logic             feed_tag;
  logic             start_req;
  logic             din_tag_q;
  logic [LATENCY-1:0] tag_pipe_q;
  logic             tags_idle;

  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        scaled;

  assign s_ready   = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && !fifo_full;
  assign fifo_push = s_valid && s_ready;
  assign busy      = (state_q != ST_IDLE);
  assign start_req = (state_q == ST_IDLE) && start && !stop;
  assign tags_idle = !din_tag_q && (tag_pipe_q == '0);

  fir_ctrl_fifo #(
    .DEPTH (DEPTH),
    .W     (DIN_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    flush_zero = 1'b0;
    feed_data  = '0;
    feed_tag   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop) state_d = ST_FLUSH;
        else if (fifo_level >= LVL_W'(PRIME_LVL)) state_d = ST_RUN;
      end
      ST_RUN: begin
        fifo_pop = !fifo_empty;
        if (stop) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Drain buffered samples, then push zeros through the delay line
        if (!fifo_empty) fifo_pop = 1'b1;
        else if (flush_cnt_q != CNT_W'(FLUSH_LEN)) flush_zero = 1'b1;
        else if (tags_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      feed_data = fifo_head;
      feed_tag  = 1'b1;
    end
  end

  assign shifted = $signed(fir_dout) >>> COEF_FRAC;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    scaled = OUT_W'(shifted);
    if (shifted > SAT_HI) scaled = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < SAT_LO) scaled = {1'b1, {(OUT_W-1){1'b0}}};
  end
`else
  assign scaled = OUT_W'(shifted);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fir_rst     <= 1'b1;
      fir_din     <= '0;
      din_tag_q   <= 1'b0;
      tag_pipe_q  <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      underrun    <= 1'b0;
      sample_cnt  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fir_rst   <= start_req;
      fir_din   <= feed_data;
      // din_tag_q mirrors fir_din; tag_pipe_q[LATENCY-1] lines up with fir_dout
      din_tag_q  <= feed_tag;
      tag_pipe_q <= {tag_pipe_q[LATENCY-2:0], din_tag_q};
      m_valid    <= tag_pipe_q[LATENCY-1];
      if (tag_pipe_q[LATENCY-1]) m_data <= scaled;

      if (state_q != ST_FLUSH) flush_cnt_q <= '0;
      else if (flush_zero) flush_cnt_q <= flush_cnt_q + CNT_W'(1);

      if (start_req) begin
        underrun   <= 1'b0;
        sample_cnt <= '0;
      end else begin
        if ((state_q == ST_RUN) && fifo_empty) underrun <= 1'b1;
        if (tag_pipe_q[LATENCY-1] && (sample_cnt != '1)) sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - scoreboard bench for fir_stream_ctrl with a 4-tap FIR model
module tb_fir_stream_ctrl;

  localparam int LATENCY   = 102;
  localparam int FLUSH_LEN = 202;
  localparam int NTAP      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [63:0] fir_dout = '0;
  logic        s_ready, fir_rst, m_valid, busy, underrun;
  logic [15:0] fir_din, m_data;
  logic [31:0] sample_cnt;

  fir_stream_ctrl #(
    .LATENCY   (LATENCY),
    .FLUSH_LEN (FLUSH_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .fir_rst    (fir_rst),
    .fir_din    (fir_din),
    .fir_dout   (fir_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .busy       (busy),
    .underrun   (underrun),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Q31 taps: 1.5, 0.25, -0.5, 0.125
  longint coef [NTAP] = '{64'sd3221225472, 64'sd536870912, -64'sd1073741824, 64'sd268435456};

  // FIR model: fir_dout shows the response to fir_din LATENCY edges after it was registered
  longint fir_hist [NTAP];
  longint yline [LATENCY+1];
  always @(negedge clk) begin
    longint y;
    if (fir_rst) begin
      for (int i = 0; i < NTAP; i++) fir_hist[i] = 0;
    end else begin
      for (int i = NTAP-1; i > 0; i--) fir_hist[i] = fir_hist[i-1];
      fir_hist[0] = longint'($signed(fir_din));
    end
    y = 0;
    for (int i = 0; i < NTAP; i++) y += coef[i] * fir_hist[i];
    for (int i = LATENCY; i > 0; i--) yline[i] = yline[i-1];
    yline[0] = y;
    fir_dout = yline[LATENCY];
  end

  longint      exp_hist [NTAP];
  logic [15:0] exp_q [$];
  int          accepted = 0;
  int          last_acc_cyc = 0;
  int          mv_count = 0;
  int          first_mv_cyc = -1;

  function automatic logic [15:0] scale_ref(input longint y);
    longint s;
    s = y >>> 31;
`ifdef FIR_OUT_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic model_push(input logic [15:0] x);
    longint y;
    for (int i = NTAP-1; i > 0; i--) exp_hist[i] = exp_hist[i-1];
    exp_hist[0] = longint'($signed(x));
    y = 0;
    for (int i = 0; i < NTAP; i++) y += coef[i] * exp_hist[i];
    exp_q.push_back(scale_ref(y));
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && m_valid) begin
      mv_count++;
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_m_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("m_data", {48'd0, m_data}, {48'd0, e});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      tick();
      s_valid = 1'b1;
      s_data  = x;
      if (s_ready) begin
        done = 1'b1;
        accepted++;
        last_acc_cyc = cyc + 1;
        model_push(x);
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic begin_session();
    for (int i = 0; i < NTAP; i++) exp_hist[i] = 0;
    exp_q.delete();
    accepted     = 0;
    mv_count     = 0;
    first_mv_cyc = -1;
  endtask

  task automatic wait_idle(input int limit, output int drop_cyc);
    drop_cyc = -1;
    for (int i = 0; i < limit && drop_cyc < 0; i++) begin
      tick();
      if (!busy) drop_cyc = cyc;
    end
    check("busy_drop", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_fir_rst"}, {63'd0, fir_rst}, 64'd1);
    check({pfx, "_s_ready"}, {63'd0, s_ready}, 64'd0);
    check({pfx, "_busy"}, {63'd0, busy}, 64'd0);
    check({pfx, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    check({pfx, "_fir_din"}, {48'd0, fir_din}, 64'd0);
    check({pfx, "_m_data"}, {48'd0, m_data}, 64'd0);
    check({pfx, "_underrun"}, {63'd0, underrun}, 64'd0);
    check({pfx, "_sample_cnt"}, {32'd0, sample_cnt}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prime_cyc;
    int stop_cyc;
    int drop_cyc;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("idle_fir_rst", {63'd0, fir_rst}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_s_ready", {63'd0, s_ready}, 64'd0);
    check("idle_m_valid_count", 64'(mv_count), 64'd0);

    tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check("start_stop_busy", {63'd0, busy}, 64'd0);
    check("start_stop_fir_rst", {63'd0, fir_rst}, 64'd0);

    // Session A: prime, steady stream, impulse, scaling, underrun, stop
    begin_session();
    pulse_start();
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_fir_rst_pulse", {63'd0, fir_rst}, 64'd1);
    tick();
    check("start_fir_rst_low", {63'd0, fir_rst}, 64'd0);
    for (int i = 0; i < 8; i++) send(16'd1000);
    prime_cyc = last_acc_cyc;
    check("prime_no_pop", {48'd0, fir_din}, 64'd0);
    for (int i = 0; i < 300; i++) send(16'd1000);
    for (int i = 0; i < 3; i++) send(16'd0);
    check("stream_underrun", {63'd0, underrun}, 64'd0);
    send(16'd32767);
    for (int i = 0; i < 5; i++) send(16'd0);
    send(16'd26667);
    for (int i = 0; i < 3; i++) send(16'd0);
    send(-16'sd26667);
    for (int i = 0; i < 3; i++) send(16'd0);
    send(16'd20000);
    for (int i = 0; i < 3; i++) send(16'd0);
    // Long enough gap to drain the primed FIFO
    repeat (20) tick();
    check("underrun_set", {63'd0, underrun}, 64'd1);
    for (int i = 0; i < 10; i++) send(16'($urandom_range(0, 65535)));
    for (int i = 0; i < 3; i++) send(16'd0);
    check("underrun_sticky", {63'd0, underrun}, 64'd1);
    tick();
    stop = 1'b1;
    wait_idle(LATENCY + FLUSH_LEN + 100, drop_cyc);
    check("first_latency", 64'(first_mv_cyc - prime_cyc), 64'(LATENCY + 3));
    check("a_queue_empty", 64'(exp_q.size()), 64'd0);
    check("a_mvalid_count", 64'(mv_count), 64'(accepted));
    check("a_sample_cnt", {32'd0, sample_cnt}, 64'(accepted));

    // Session B: stop from PRIME with 6 buffered samples
    begin_session();
    pulse_start();
    for (int i = 0; i < 6; i++) send(16'(500 + 100 * i));
    tick();
    stop = 1'b1;
    stop_cyc = cyc + 1;
    tick();
    check("flush_s_ready", {63'd0, s_ready}, 64'd0);
    start = 1'b1;
    tick();
    check("flush_ignores_start_busy", {63'd0, busy}, 64'd1);
    check("flush_ignores_start_rst", {63'd0, fir_rst}, 64'd0);
    wait_idle(LATENCY + FLUSH_LEN + 100, drop_cyc);
    check("flush_duration", 64'(drop_cyc - stop_cyc), 64'(6 + FLUSH_LEN + 1));
    check("b_mvalid_count", 64'(mv_count), 64'd6);
    check("b_sample_cnt", {32'd0, sample_cnt}, 64'd6);
    check("b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Session C: reset while running
    begin_session();
    pulse_start();
    for (int i = 0; i < 8; i++) send(16'd1234);
    repeat (15) tick();
    check("c_underrun", {63'd0, underrun}, 64'd1);
    for (int i = 0; i < 3; i++) send(16'd777);
    tick();
    check("pre_rst_fir_din", {48'd0, fir_din}, 64'd777);
    rst = 1'b1;
    tick();
    check_reset_values("abort");
    exp_q.delete();
    rst = 1'b0;
    repeat (3) tick();
    check("post_abort_busy", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
